operand_select: RTL and testbench

Registered, parametrised operand/constant selector for the CPU datapath. Each accepted request either passes a datapath word through or substitutes an entry from a small constant table. Requests and results use valid/ready handshakes with one cycle of latency. It sits between register-file/immediate decode and the ALU B-operand input, and replaces hard-wired constant selection with a sized, optionally programmable table, error reporting and back-pressure.

---
 rtl/operand_select_pkg.sv | 17 +
 rtl/operand_select_if.sv | 29 ++
 rtl/operand_select_table.sv | 59 +++++
 rtl/operand_select.sv | 82 ++++++++
 tb/tb_operand_select.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/operand_select_pkg.sv
// Shared constants for the operand/constant selector: default constant table
// contents and the pass-through select code.
package operand_select_pkg;

   localparam int DEFAULT_LEN = 10;
   localparam int DEFAULT_CONST [DEFAULT_LEN] = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 15};
   localparam int SEL_PASS = 0;

   // Reset value of table entry idx; entries past the default list are zero.
   function automatic int const_default(input int idx);
      if (idx < DEFAULT_LEN)
         return DEFAULT_CONST[idx];
      else
         return 0;
   endfunction

endpackage

// File: rtl/operand_select_if.sv
// Request/result handshake, table write port and error counter of operand_select.
interface operand_select_if #(
   parameter int WIDTH = 17,
   parameter int SEL_W = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SEL_W-1:0] in_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_err;
   logic             wr_en;
   logic [SEL_W-1:0] wr_idx;
   logic [WIDTH-1:0] wr_data;
   logic [CNT_W-1:0] err_count;

   modport master (
      output in_valid, in_data, in_sel, out_ready, wr_en, wr_idx, wr_data,
      input  in_ready, out_valid, out_data, out_err, err_count
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready, wr_en, wr_idx, wr_data,
      output in_ready, out_valid, out_data, out_err, err_count
   );
endinterface

// File: rtl/operand_select_table.sv
// Constant table with combinational read by select code (1..NUM_CONST).
// Writable register array when OPERAND_SELECT_CONST_WR_EN is defined, ROM otherwise.
module operand_select_table
   import operand_select_pkg::*;
#(
   parameter int WIDTH     = 17,
   parameter int NUM_CONST = 10,
   parameter int SEL_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_hit
);

   logic [WIDTH-1:0] table_word [NUM_CONST];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CONST; gi++) begin : g_entry
`ifdef OPERAND_SELECT_CONST_WR_EN
         logic [WIDTH-1:0] entry_reg;

         // Out-of-range write indices match no entry and are dropped here.
         always_ff @(posedge clk) begin
            if (reset)
               entry_reg <= WIDTH'(const_default(gi));
            else if (wr_en && (wr_idx == SEL_W'(gi)))
               entry_reg <= wr_data;
         end

         assign table_word[gi] = entry_reg;
`else
         assign table_word[gi] = WIDTH'(const_default(gi));
`endif
      end
   endgenerate

`ifndef OPERAND_SELECT_CONST_WR_EN
   wire unused_wr = &{1'b0, clk, reset, wr_en, wr_idx, wr_data};
`endif

   // Select code k reads entry k-1; code 0 and codes past the table miss.
   always_comb begin
      rd_data = '0;
      rd_hit  = 1'b0;
      for (int i = 0; i < NUM_CONST; i++) begin
         if (rd_sel == SEL_W'(i + 1)) begin
            rd_data = table_word[i];
            rd_hit  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/operand_select.sv
// Registered operand/constant selector with valid/ready handshake, one-cycle
// latency and a saturating illegal-select counter. Optional: OPERAND_SELECT_CONST_WR_EN.
module operand_select
   import operand_select_pkg::*;
#(
   parameter int WIDTH     = 17,
   parameter int NUM_CONST = 10,
   parameter int SEL_W     = 4,
   parameter int CNT_W     = 8
) (
   input logic                clk,
   input logic                reset,
   operand_select_if.slave    bus
);

   logic             out_valid_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic             out_err_reg;
   logic [CNT_W-1:0] err_count_reg;

   logic             ready;
   logic             accept;
   logic [WIDTH-1:0] rd_data;
   logic             rd_hit;
   logic [WIDTH-1:0] sel_data;
   logic             sel_err;

   operand_select_table #(
      .WIDTH     (WIDTH),
      .NUM_CONST (NUM_CONST),
      .SEL_W     (SEL_W)
   ) u_table (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.wr_en),
      .wr_idx  (bus.wr_idx),
      .wr_data (bus.wr_data),
      .rd_sel  (bus.in_sel),
      .rd_data (rd_data),
      .rd_hit  (rd_hit)
   );

   assign ready  = !out_valid_reg || bus.out_ready;
   assign accept = bus.in_valid && ready;

   always_comb begin
      sel_data = '0;
      sel_err  = 1'b0;
      if (bus.in_sel == SEL_W'(SEL_PASS))
         sel_data = bus.in_data;
      else if (rd_hit)
         sel_data = rd_data;
      else
         sel_err = 1'b1;
   end

   // Table is read combinationally before the edge, so a same-cycle write
   // to the selected entry is seen only by later accepts.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_err_reg   <= 1'b0;
         err_count_reg <= '0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= sel_data;
         out_err_reg   <= sel_err;
         if (sel_err && (err_count_reg != {CNT_W{1'b1}}))
            err_count_reg <= err_count_reg + CNT_W'(1);
      end else if (bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.out_err   = out_err_reg;
   assign bus.err_count = err_count_reg;

endmodule

// File: tb/tb_operand_select.sv
// Directed, table-driven bench for operand_select plus hand-written stall,
// collision, reset and counter-saturation sequences.
module tb_operand_select;

`ifdef OPERAND_SELECT_CONST_WR_EN
   localparam bit WR_BUILD = 1'b1;
`else
   localparam bit WR_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   operand_select_if #(.WIDTH(17), .SEL_W(4), .CNT_W(8)) bus ();
   operand_select_if #(.WIDTH(17), .SEL_W(4), .CNT_W(2)) bus2 ();

   operand_select #(.WIDTH(17), .NUM_CONST(10), .SEL_W(4), .CNT_W(8)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   operand_select #(.WIDTH(17), .NUM_CONST(10), .SEL_W(4), .CNT_W(2)) u_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   typedef struct {
      logic [3:0]  sel;
      logic [16:0] data;
      logic [16:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic v, input logic [16:0] d,
                            input logic e, input logic r);
      chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(v));
      chk({name, ".out_data"},  32'(bus.out_data),  32'(d));
      chk({name, ".out_err"},   32'(bus.out_err),   32'(e));
      chk({name, ".in_ready"},  32'(bus.in_ready),  32'(r));
   endtask

   task automatic req(input logic [3:0] sel, input logic [16:0] data);
      bus.in_valid = 1'b1;
      bus.in_sel   = sel;
      bus.in_data  = data;
   endtask

   initial begin
      int exp_cnt;
      logic [16:0] exp_d;

      vecs[0]  = '{4'd0,  17'h1ABCD, 17'h1ABCD, 1'b0};
      vecs[1]  = '{4'd1,  17'h1FFFF, 17'd0,     1'b0};
      vecs[2]  = '{4'd2,  17'h1FFFF, 17'd1,     1'b0};
      vecs[3]  = '{4'd3,  17'h1FFFF, 17'd2,     1'b0};
      vecs[4]  = '{4'd4,  17'h1FFFF, 17'd3,     1'b0};
      vecs[5]  = '{4'd5,  17'h1FFFF, 17'd4,     1'b0};
      vecs[6]  = '{4'd6,  17'h1FFFF, 17'd6,     1'b0};
      vecs[7]  = '{4'd7,  17'h1FFFF, 17'd7,     1'b0};
      vecs[8]  = '{4'd8,  17'h1FFFF, 17'd8,     1'b0};
      vecs[9]  = '{4'd9,  17'h1FFFF, 17'd9,     1'b0};
      vecs[10] = '{4'd10, 17'h1FFFF, 17'd15,    1'b0};
      vecs[11] = '{4'd12, 17'h00123, 17'd0,     1'b1};
      vecs[12] = '{4'd12, 17'h00123, 17'd0,     1'b1};
      vecs[13] = '{4'd12, 17'h00123, 17'd0,     1'b1};
      vecs[14] = '{4'd15, 17'h0F0F0, 17'd0,     1'b1};
      vecs[15] = '{4'd11, 17'h00001, 17'd0,     1'b1};

      reset = 1'b1;
      bus.in_valid  = 1'b0; bus.in_sel  = '0; bus.in_data  = '0; bus.out_ready  = 1'b1;
      bus.wr_en     = 1'b0; bus.wr_idx  = '0; bus.wr_data  = '0;
      bus2.in_valid = 1'b0; bus2.in_sel = '0; bus2.in_data = '0; bus2.out_ready = 1'b1;
      bus2.wr_en    = 1'b0; bus2.wr_idx = '0; bus2.wr_data = '0;
      tick();
      tick();
      reset = 1'b0;

      check_out("reset", 1'b0, 17'd0, 1'b0, 1'b1);
      chk("reset.err_count", 32'(bus.err_count), 32'd0);

      // Back-to-back sweep: pass-through, every table entry, illegal codes.
      exp_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         req(vecs[i].sel, vecs[i].data);
         tick();
         if (vecs[i].exp_err) exp_cnt++;
         check_out($sformatf("vec%0d_sel%0d", i, vecs[i].sel), 1'b1,
                   vecs[i].exp_data, vecs[i].exp_err, 1'b1);
         chk($sformatf("vec%0d.err_count", i), 32'(bus.err_count), 32'(exp_cnt));
      end
      bus.in_valid = 1'b0;
      tick();
      chk("drain.out_valid", 32'(bus.out_valid), 32'd0);

      // Saturation on the CNT_W=2 instance: six illegal accepts.
      for (int i = 0; i < 6; i++) begin
         bus2.in_valid = 1'b1;
         bus2.in_sel   = 4'd12;
         tick();
         chk($sformatf("sat%0d.err_count", i), 32'(bus2.err_count), (i < 3) ? 32'(i + 1) : 32'd3);
         chk($sformatf("sat%0d.out_err", i), 32'(bus2.out_err), 32'd1);
      end
      bus2.in_valid = 1'b0;

      // Stall: hold out_ready low 4 cycles with a pending request and a table write.
      bus.out_ready = 1'b0;
      req(4'd3, 17'h0);
      tick();
      check_out("stall_accept", 1'b1, 17'd2, 1'b0, 1'b0);
      req(4'd6, 17'h0);
      bus.wr_en = 1'b1; bus.wr_idx = 4'd4; bus.wr_data = 17'h00055;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.wr_en = 1'b0;
         check_out($sformatf("stall%0d", i), 1'b1, 17'd2, 1'b0, 1'b0);
      end
      chk("stall.err_count", 32'(bus.err_count), 32'd5);
      bus.out_ready = 1'b1;
      tick();
      check_out("drain_accept", 1'b1, 17'd6, 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      tick();
      chk("idle.out_valid", 32'(bus.out_valid), 32'd0);

      // Same-cycle accept and write of the same entry returns the old value.
      req(4'd3, 17'h0);
      bus.wr_en = 1'b1; bus.wr_idx = 4'd2; bus.wr_data = 17'd5;
      tick();
      bus.wr_en = 1'b0;
      check_out("collide_old", 1'b1, 17'd2, 1'b0, 1'b1);
      req(4'd3, 17'h0);
      tick();
      check_out("collide_new", 1'b1, WR_BUILD ? 17'd5 : 17'd2, 1'b0, 1'b1);

      // Out-of-range write is dropped without touching err_count.
      bus.in_valid = 1'b0;
      bus.wr_en = 1'b1; bus.wr_idx = 4'd12; bus.wr_data = 17'h1FFFF;
      tick();
      bus.wr_en = 1'b0;
      chk("wr_oob.err_count", 32'(bus.err_count), 32'd5);
      req(4'd5, 17'h0);
      tick();
      check_out("stall_write", 1'b1, WR_BUILD ? 17'h00055 : 17'd4, 1'b0, 1'b1);
      req(4'd10, 17'h0);
      tick();
      check_out("after_oob", 1'b1, 17'd15, 1'b0, 1'b1);

      // Reset wins over a simultaneous illegal accept and write; table reverts.
      bus.out_ready = 1'b0;
      req(4'd13, 17'h0);
      tick();
      reset = 1'b1;
      req(4'd13, 17'h0);
      bus.wr_en = 1'b1; bus.wr_idx = 4'd0; bus.wr_data = 17'h1FFFF;
      tick();
      reset = 1'b0;
      bus.wr_en = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      check_out("mid_reset", 1'b0, 17'd0, 1'b0, 1'b1);
      chk("mid_reset.err_count", 32'(bus.err_count), 32'd0);
      chk("mid_reset.sat_count", 32'(bus2.err_count), 32'd0);
      exp_d = 17'd2;
      req(4'd3, 17'h0);
      tick();
      check_out("revert_sel3", 1'b1, exp_d, 1'b0, 1'b1);
      req(4'd1, 17'h0);
      tick();
      check_out("revert_sel1", 1'b1, 17'd0, 1'b0, 1'b1);
      req(4'd5, 17'h0);
      tick();
      check_out("revert_sel5", 1'b1, 17'd4, 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
